// File: rtl/reg_file.sv
// General-purpose register file: 2 async read ports, 1 sync write port, r0 = 0.
// Define REGFILE_BYPASS_EN to forward write_data to matching read ports pre-edge.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] read1_sel,
  input  logic [ADDR_WIDTH-1:0] read2_sel,
  input  logic [ADDR_WIDTH-1:0] write_sel,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  wr_en;

  assign wr_en = write && (write_sel != '0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[write_sel] = write_data;
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is masked during reset so outputs stay zero.
  logic fwd1;
  logic fwd2;

  assign fwd1 = wr_en && !reset && (read1_sel == write_sel);
  assign fwd2 = wr_en && !reset && (read2_sel == write_sel);

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (fwd1) begin
      read_data1 = write_data;
    end else if (read1_sel != '0) begin
      read_data1 = mem_q[read1_sel];
    end
    if (fwd2) begin
      read_data2 = write_data;
    end else if (read2_sel != '0) begin
      read_data2 = mem_q[read2_sel];
    end
  end
`else
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (read1_sel != '0) begin
      read_data1 = mem_q[read1_sel];
    end
    if (read2_sel != '0) begin
      read_data2 = mem_q[read2_sel];
    end
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: vector table plus same-cycle and reset sequences.
// Honours REGFILE_BYPASS_EN for the pre-edge forwarding expectation.
module tb_reg_file;

  logic        clock;
  logic        reset;
  logic        write;
  logic [4:0]  read1_sel;
  logic [4:0]  read2_sel;
  logic [4:0]  write_sel;
  logic [31:0] write_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int n_pass;
  int n_total;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .write      (write),
    .read1_sel  (read1_sel),
    .read2_sel  (read2_sel),
    .write_sel  (write_sel),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  ws;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    string       name;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] ws,
                       input logic [31:0] wd, input logic [4:0] r1,
                       input logic [4:0] r2);
    write      = we;
    write_sel  = ws;
    write_data = wd;
    read1_sel  = r1;
    read2_sel  = r2;
  endtask

  initial begin
    logic [31:0] pre_exp;

    vecs[0] = '{1'b1, 5'd1, 32'h2, 5'd1, 5'd1, 32'h2, 32'h2, "wr_r1"};
    vecs[1] = '{1'b1, 5'd3, 32'h5, 5'd3, 5'd1, 32'h5, 32'h2, "wr_r3"};
    vecs[2] = '{1'b1, 5'd7, 32'h9, 5'd7, 5'd7, 32'h9, 32'h9, "wr_r7"};
    vecs[3] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 32'h9, 32'h9, "rd_r7r7"};
    vecs[4] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd1, 32'h5, 32'h2, "rd_r3r1"};
    vecs[5] = '{1'b1, 5'd0, 32'h7, 5'd0, 5'd1, 32'h0, 32'h2, "wr_r0"};
    vecs[6] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd1, 32'h0, 32'h2, "rd_r0r1"};
    vecs[7] = '{1'b1, 5'd5, 32'hA, 5'd5, 5'd5, 32'hA, 32'hA, "wr_r5"};
    vecs[8] = '{1'b0, 5'd5, 32'hB, 5'd5, 5'd5, 32'hA, 32'hA, "nowr_r5"};
    vecs[9] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 32'h5, 32'h9, "rd_r3r7"};

    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    drive(1'b1, 5'd1, 32'hDEAD, 5'd1, 5'd7);
    @(posedge clock);
    #1;
    chk("reset_rd1", read_data1, 32'h0);
    chk("reset_rd2", read_data2, 32'h0);

    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd7);
    #1;
    chk("post_reset_rd1", read_data1, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].we, vecs[i].ws, vecs[i].wd, vecs[i].r1, vecs[i].r2);
      @(posedge clock);
      #1;
      chk({vecs[i].name, "_p1"}, read_data1, vecs[i].e1);
      chk({vecs[i].name, "_p2"}, read_data2, vecs[i].e2);
    end

    // Same-cycle read and write of r5.
    @(negedge clock);
    drive(1'b1, 5'd5, 32'hC, 5'd5, 5'd5);
    #1;
`ifdef REGFILE_BYPASS_EN
    pre_exp = 32'hC;
`else
    pre_exp = 32'hA;
`endif
    chk("same_pre_p1", read_data1, pre_exp);
    chk("same_pre_p2", read_data2, pre_exp);
    @(posedge clock);
    #1;
    chk("same_post_p1", read_data1, 32'hC);
    chk("same_post_p2", read_data2, 32'hC);

    // r0 with a write pending to it still reads zero.
    @(negedge clock);
    drive(1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
    #1;
    chk("r0_pending", read_data1, 32'h0);

    // Async reset between edges, with a write attempted during reset.
    @(negedge clock);
    drive(1'b1, 5'd5, 32'hFF, 5'd5, 5'd7);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_p1", read_data1, 32'h0);
    chk("async_rst_p2", read_data2, 32'h0);
    @(posedge clock);
    #1;
    chk("rst_wr_ign", read_data1, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    #1;
    chk("after_rst_r5", read_data1, 32'h0);
    chk("after_rst_r7", read_data2, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd1);
    #1;
    chk("after_rst_r3", read_data1, 32'h0);
    chk("after_rst_r1", read_data2, 32'h0);

    // First write after reset lands on the next edge.
    @(negedge clock);
    drive(1'b1, 5'd2, 32'h33, 5'd2, 5'd31);
    @(posedge clock);
    #1;
    chk("post_rst_wr", read_data1, 32'h33);
    chk("r31_zero", read_data2, 32'h0);

    @(negedge clock);
    drive(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd2, 5'd31);
    @(posedge clock);
    #1;
    chk("r31_wr_p1", read_data1, 32'h33);
    chk("r31_wr_p2", read_data2, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
